// File: rtl/tanh_pkg.sv
// tanh_pkg: shared constants for the piecewise-linear tanh unit.
//   DEF_ADDR_W / DEF_FRAC_W / DEF_DATA_W : default geometry
//   DEF_LUT                              : 16 x 8 reset table for the default geometry
//   next_addr()                          : index of the interpolation partner entry
package tanh_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_FRAC_W = 4;
    localparam int DEF_DATA_W = 8;

    // Index order follows the two's-complement input: 0..7 positive, 8..15 negative.
    localparam logic signed [7:0] DEF_LUT [16] = '{
        8'sd0,   8'sd12,  8'sd15,  8'sd15,  8'sd15,  8'sd15,  8'sd15,  8'sd15,
        -8'sd15, -8'sd15, -8'sd15, -8'sd15, -8'sd15, -8'sd15, -8'sd15, -8'sd12
    };

    // The last negative segment interpolates across zero into entry 0; the
    // top positive segment has no successor, so it pairs with itself and saturates.
    function automatic int next_addr(input int addr, input int addr_w);
        if (addr == (1 << addr_w) - 1)
            return 0;
        if (addr == (1 << (addr_w - 1)) - 1)
            return addr;
        return addr + 1;
    endfunction

endpackage

// File: rtl/tanh_pwl_pipe_if.sv
// tanh_pwl_pipe_if: sample stream in, result stream out, and the LUT write port.
//   in_valid/in_ready/in_x     : input stream (in_x signed, ADDR_W+FRAC_W bits)
//   out_valid/out_ready/out_y  : result stream (out_y signed, DATA_W bits)
//   lut_we/lut_waddr/lut_wdata : LUT write strobe, address, signed data
//   slave modport: the tanh unit; master modport: the producer/consumer side.
interface tanh_pwl_pipe_if
    import tanh_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int DATA_W = DEF_DATA_W
);
    localparam int IN_W = ADDR_W + FRAC_W;

    logic                     in_valid;
    logic                     in_ready;
    logic [IN_W-1:0]          in_x;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_y;
    logic                     lut_we;
    logic [ADDR_W-1:0]        lut_waddr;
    logic signed [DATA_W-1:0] lut_wdata;

    modport slave (
        input  in_valid, in_x, out_ready, lut_we, lut_waddr, lut_wdata,
        output in_ready, out_valid, out_y
    );

    modport master (
        output in_valid, in_x, out_ready, lut_we, lut_waddr, lut_wdata,
        input  in_ready, out_valid, out_y
    );

endinterface

// File: rtl/tanh_lut_rf.sv
// tanh_lut_rf: 2^ADDR_W x DATA_W register file holding the tanh breakpoints.
//   clk, reset      : clock, async active-high reset (loads the default table)
//   we/waddr/wdata  : single write port, takes effect at the clock edge
//   raddr           : segment index
//   base, next      : combinational reads of the segment start and its partner
module tanh_lut_rf
    import tanh_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic signed [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0]        raddr,
    output logic signed [DATA_W-1:0] base,
    output logic signed [DATA_W-1:0] next
);
    localparam int  DEPTH   = 2 ** ADDR_W;
    // The packaged table only makes sense for the geometry it was built for.
    localparam bit  USE_DEF = (ADDR_W == DEF_ADDR_W) && (DATA_W == DEF_DATA_W);

    logic signed [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]        naddr;

    assign naddr = ADDR_W'(next_addr(int'(raddr), ADDR_W));
    assign base  = mem[raddr];
    assign next  = mem[naddr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= USE_DEF ? DATA_W'(DEF_LUT[i[3:0]]) : '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/tanh_pwl_pipe.sv
// tanh_pwl_pipe: 3-stage pipelined piecewise-linear tanh.
//   clk, reset : clock, async active-high reset (drops in-flight samples)
//   bus        : slave side of tanh_pwl_pipe_if (streams + LUT write port)
// Stage 1 reads base/next from the LUT, stage 2 multiplies the segment delta
// by the fraction, stage 3 adds the floored scaled delta back onto base.
// A single enable stalls every stage when the output is held.
module tanh_pwl_pipe
    import tanh_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic          clk,
    input  logic          reset,
    tanh_pwl_pipe_if.slave bus
);
    localparam int IN_W = ADDR_W + FRAC_W;
    localparam int PW   = DATA_W + FRAC_W + 1;

    logic                     en, acc;
    logic [3:1]               vld_pipe;
    logic [ADDR_W-1:0]        addr;
    logic signed [DATA_W-1:0] lut_base, lut_next;

    logic signed [DATA_W-1:0] s1_base, s1_next;
    logic [FRAC_W-1:0]        s1_frac;
    logic signed [DATA_W-1:0] s2_base;
    logic signed [PW-1:0]     s2_prod;
    logic signed [DATA_W-1:0] s3_y;

    logic signed [DATA_W:0]   diff_c;
    logic signed [PW-1:0]     diff_x, frac_x, prod_c;
    logic signed [DATA_W-1:0] y_c;

    assign en  = bus.out_ready | ~vld_pipe[3];
    assign acc = bus.in_valid & en;

    assign bus.in_ready  = en;
    assign bus.out_valid = vld_pipe[3];
    assign bus.out_y     = s3_y;

    assign addr = bus.in_x[IN_W-1 -: ADDR_W];

    tanh_lut_rf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_lut (
        .clk   (clk),
        .reset (reset),
        .we    (bus.lut_we),
        .waddr (bus.lut_waddr),
        .wdata (bus.lut_wdata),
        .raddr (addr),
        .base  (lut_base),
        .next  (lut_next)
    );

    // One extra bit on the delta covers the full span between two entries;
    // the fraction is zero-extended so it never reads as negative.
    assign diff_c = (DATA_W+1)'(s1_next) - (DATA_W+1)'(s1_base);
    assign diff_x = PW'(diff_c);
    assign frac_x = PW'({1'b0, s1_frac});
    assign prod_c = diff_x * frac_x;

    // Result lies between base and next, so truncation to DATA_W is lossless.
    assign y_c = DATA_W'(PW'(s2_base) + (s2_prod >>> FRAC_W));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            s1_base  <= '0;
            s1_next  <= '0;
            s1_frac  <= '0;
            s2_base  <= '0;
            s2_prod  <= '0;
            s3_y     <= '0;
        end else if (en) begin
            vld_pipe <= {vld_pipe[2:1], acc};
            s1_base  <= lut_base;
            s1_next  <= lut_next;
            s1_frac  <= bus.in_x[FRAC_W-1:0];
            s2_base  <= s1_base;
            s2_prod  <= prod_c;
            s3_y     <= y_c;
        end
    end

endmodule

// File: tb/tb_tanh_pwl_pipe.sv
// Bench for tanh_pwl_pipe: directed cases, streaming with backpressure, a LUT
// write collision, mid-stream reset and a randomized phase, all checked
// against a queue-based reference built from plain integer arithmetic.
module tb_tanh_pwl_pipe;

    localparam int NOEXP = 999;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tanh_pwl_pipe_if #(.ADDR_W(4), .FRAC_W(4), .DATA_W(8)) bus ();

    tanh_pwl_pipe #(.ADDR_W(4), .FRAC_W(4), .DATA_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int y;
        int due;
    } exp_t;

    exp_t q[$];
    int   lut_m [16];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    task automatic load_default();
        int tbl [16] = '{0, 12, 15, 15, 15, 15, 15, 15,
                         -15, -15, -15, -15, -15, -15, -15, -12};
        for (int i = 0; i < 16; i++) lut_m[i] = tbl[i];
    endtask

    // tanh(x) ~ base + floor((next - base) * frac / 16)
    function automatic int ref_y(input logic [7:0] x);
        int a, f, n, b, p, r;
        a = int'(x[7:4]);
        f = int'(x[3:0]);
        if (a == 15)     n = 0;
        else if (a == 7) n = 7;
        else             n = a + 1;
        b = lut_m[a];
        p = (lut_m[n] - b) * f;
        r = p / 16;
        if (p < 0 && (p % 16) != 0) r = r - 1;
        return b + r;
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One clock: drive at the falling edge, check outputs, update the model,
    // then let the rising edge happen.
    task automatic step(input bit iv, input logic [7:0] x, input bit ordy,
                        input bit we, input logic [3:0] wa, input logic [7:0] wd,
                        input int ey, output bit acc);
        bit   exp_v;
        exp_t e;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_x      = x;
        bus.out_ready = ordy;
        bus.lut_we    = we;
        bus.lut_waddr = wa;
        bus.lut_wdata = wd;
        #1;
        exp_v = (q.size() > 0) && (cyc >= q[0].due);
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_v});
        if (exp_v) chk("out_y", 32'($signed(bus.out_y)), 32'(q[0].y));
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, (ordy | ~exp_v)});
        acc = iv && (ordy || !exp_v);
        if (exp_v && ordy) begin
            void'(q.pop_front());
        end else if (exp_v) begin
            foreach (q[i]) q[i].due++;
        end
        if (acc) begin
            e.y   = (ey == NOEXP) ? ref_y(x) : ey;
            e.due = cyc + 3;
            q.push_back(e);
        end
        if (we) lut_m[wa] = int'($signed(wd));
        @(posedge clk);
        cyc++;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int sent;
        int xs [10];

        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.out_ready = 1'b1;
        bus.lut_we    = 1'b0;
        bus.lut_waddr = '0;
        bus.lut_wdata = '0;
        load_default();

        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_y", 32'($signed(bus.out_y)), 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Directed segments
        step(1, 8'h08, 1, 0, 4'd0, 8'd0, 6, acc);
        step(1, 8'h18, 1, 0, 4'd0, 8'd0, 13, acc);
        step(1, 8'h7F, 1, 0, 4'd0, 8'd0, 15, acc);
        step(1, 8'hF8, 1, 0, 4'd0, 8'd0, -6, acc);
        step(1, 8'h88, 1, 0, 4'd0, 8'd0, -15, acc);

        // Write lut[1]=20 alongside a read of segment 1: old data, then new
        // (base 20, next 15, frac 8: 20 + floor(-40/16) = 17)
        step(1, 8'h18, 1, 1, 4'd1, 8'd20, 13, acc);
        step(1, 8'h18, 1, 0, 4'd0, 8'd0, 17, acc);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 4'd0, 8'd0, NOEXP, acc);

        // Ten back-to-back samples with a 4-cycle output stall mid-stream
        for (int i = 0; i < 10; i++) xs[i] = int'($urandom_range(0, 255));
        sent = 0;
        for (int i = 0; i < 40 && sent < 10; i++) begin
            step(1, 8'(xs[sent]), !(i >= 4 && i < 8), 0, 4'd0, 8'd0, NOEXP, acc);
            if (acc) sent++;
        end
        chk("stream_sent", sent, 10);
        for (int i = 0; i < 6; i++) step(0, 8'h00, 1, 0, 4'd0, 8'd0, NOEXP, acc);
        chk("stream_drained", q.size(), 0);

        // Fill all three stages, then reset asynchronously
        for (int i = 0; i < 3; i++)
            step(1, 8'($urandom_range(0, 255)), 1, 0, 4'd0, 8'd0, NOEXP, acc);
        @(negedge clk);
        chk("pre_reset_valid", {31'd0, bus.out_valid}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_y", 32'($signed(bus.out_y)), 32'd0);
        q.delete();
        load_default();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        step(1, 8'h08, 0, 0, 4'd0, 8'd0, 6, acc);
        step(1, 8'h18, 1, 0, 4'd0, 8'd0, 13, acc);

        // Randomized traffic with random LUT writes and backpressure
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 7) == 0,
                 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                 NOEXP, acc);
        end
        for (int i = 0; i < 20 && q.size() > 0; i++)
            step(0, 8'h00, 1, 0, 4'd0, 8'd0, NOEXP, acc);
        chk("final_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
